// File: rtl/kmin_pkg.sv
// +--------------------------------------------------------------------------+
// | kmin_pkg : shared defaults and counter-mode enum for kmin_tracker        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package kmin_pkg;

  localparam int DW_DEF = 10;
  localparam int K_DEF  = 4;
  localparam int CW_DEF = 9;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

`default_nettype wire

// File: rtl/kmin_slot.sv
// +--------------------------------------------------------------------------+
// | kmin_slot : one ranked entry register with lt/eq compare against din     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module kmin_slot
  import kmin_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int CW      = CW_DEF,
  parameter int SAT_CNT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_i,
  input  logic          left_vld_i,
  input  logic [DW-1:0] left_val_i,
  input  logic [CW-1:0] left_cnt_i,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic          hit_i,
  output logic          vld_o,
  output logic [DW-1:0] val_o,
  output logic [CW-1:0] cnt_o,
  output logic          lt_o,
  output logic          eq_o
);

  localparam cnt_mode_e CNT_MODE = (SAT_CNT != 0) ? CNT_SAT : CNT_WRAP;

  logic          vld_q, vld_d;
  logic [DW-1:0] val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc_w;

  assign cnt_inc_w = ((CNT_MODE == CNT_SAT) && (&cnt_q)) ? cnt_q : cnt_q + CW'(1);

  // Load beats clear so a restart with a sample lands in one cycle.
  always_comb begin
    vld_d = vld_q;
    val_d = val_q;
    cnt_d = cnt_q;
    if (load_i) begin
      vld_d = 1'b1;
      val_d = din_i;
      cnt_d = CW'(1);
    end else if (clr_i) begin
      vld_d = 1'b0;
      val_d = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      vld_d = left_vld_i;
      val_d = left_val_i;
      cnt_d = left_cnt_i;
    end else if (hit_i) begin
      cnt_d = cnt_inc_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign vld_o = vld_q;
  assign val_o = val_q;
  assign cnt_o = cnt_q;
  assign lt_o  = vld_q && (val_q < din_i);
  assign eq_o  = vld_q && (val_q == din_i);

endmodule

`default_nettype wire

// File: rtl/kmin_tracker.sv
// +--------------------------------------------------------------------------+
// | kmin_tracker : K smallest distinct values with per-value occurrence cnt  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module kmin_tracker
  import kmin_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int K       = K_DEF,
  parameter int CW      = CW_DEF,
  parameter int SAT_CNT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic [DW-1:0]          din_i,
  input  logic                   din_vld_i,
  input  logic [$clog2(K)-1:0]   rank_sel_i,
  output logic [DW-1:0]          dout_o,
  output logic [CW-1:0]          cnt_o,
  output logic                   dout_vld_o,
  output logic [$clog2(K+1)-1:0] num_vld_o
);

  localparam int SW   = $clog2(K);
  localparam int NW   = $clog2(K+1);
  localparam int NSEL = 1 << SW;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] val;
    logic [CW-1:0] cnt;
  } slot_t;

  slot_t         slots_w [K];
  slot_t         left_w  [K];
  slot_t         rd_w    [NSEL];
  logic [K-1:0]  vld_w, lt_w, eq_w;
  logic [DW-1:0] val_w [K];
  logic [CW-1:0] cnt_w [K];
  logic [K-1:0]  prev_lt_w, load_w, hit_w, shift_w;
  logic          any_hit_w;
  logic [NW-1:0] num_w;
  slot_t         sel_w;

  // lt flags form a thermometer (sorted, contiguous), so slot p is the
  // first slot whose lt is low while its left neighbour's lt is high.
  always_comb begin
    any_hit_w    = |eq_w;
    left_w[0]    = '0;
    prev_lt_w[0] = 1'b1;
    for (int i = 1; i < K; i++) begin
      left_w[i]    = slots_w[i-1];
      prev_lt_w[i] = lt_w[i-1];
    end
    for (int i = 0; i < K; i++) begin
      load_w[i]  = din_vld_i && (clr_i ? (i == 0)
                                       : (prev_lt_w[i] && !lt_w[i] && !eq_w[i]));
      hit_w[i]   = din_vld_i && !clr_i && prev_lt_w[i] && !lt_w[i] && eq_w[i];
      shift_w[i] = din_vld_i && !clr_i && !any_hit_w && !prev_lt_w[i];
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_slot
    kmin_slot #(
      .DW      (DW),
      .CW      (CW),
      .SAT_CNT (SAT_CNT)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .din_i      (din_i),
      .left_vld_i (left_w[i].vld),
      .left_val_i (left_w[i].val),
      .left_cnt_i (left_w[i].cnt),
      .load_i     (load_w[i]),
      .clr_i      (clr_i),
      .shift_i    (shift_w[i]),
      .hit_i      (hit_w[i]),
      .vld_o      (vld_w[i]),
      .val_o      (val_w[i]),
      .cnt_o      (cnt_w[i]),
      .lt_o       (lt_w[i]),
      .eq_o       (eq_w[i])
    );
    assign slots_w[i] = {vld_w[i], val_w[i], cnt_w[i]};
  end

  for (genvar i = 0; i < NSEL; i++) begin : g_rd
    if (i < K) begin : g_real
      assign rd_w[i] = slots_w[i];
    end else begin : g_pad
      assign rd_w[i] = '0;
    end
  end

  always_comb begin
    num_w = '0;
    for (int i = 0; i < K; i++) begin
      num_w = num_w + NW'(vld_w[i]);
    end
  end

  assign sel_w      = rd_w[rank_sel_i];
  assign dout_vld_o = sel_w.vld;
  assign dout_o     = sel_w.vld ? sel_w.val : '0;
  assign cnt_o      = sel_w.vld ? sel_w.cnt : '0;
  assign num_vld_o  = num_w;

endmodule

`default_nettype wire

// File: tb/tb_kmin_tracker.sv
// +--------------------------------------------------------------------------+
// | tb_kmin_tracker : queue-model bench for kmin_tracker (CW=9 and CW=2)     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_kmin_tracker;

  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [9:0] din = '0;
  logic       din_vld = 1'b0;
  logic [1:0] rank_sel = '0;

  logic [9:0] dout_m, dout_w, dout_s;
  logic [8:0] cnt_m;
  logic [1:0] cnt_w, cnt_s;
  logic       dv_m, dv_w, dv_s;
  logic [2:0] nv_m, nv_w, nv_s;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int val;
    int cnt;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  kmin_tracker #(.DW(10), .K(K), .CW(9), .SAT_CNT(0)) u_main (
    .clk(clk), .rst(rst), .clr_i(clr), .din_i(din), .din_vld_i(din_vld),
    .rank_sel_i(rank_sel), .dout_o(dout_m), .cnt_o(cnt_m),
    .dout_vld_o(dv_m), .num_vld_o(nv_m));

  kmin_tracker #(.DW(10), .K(K), .CW(2), .SAT_CNT(0)) u_wrap (
    .clk(clk), .rst(rst), .clr_i(clr), .din_i(din), .din_vld_i(din_vld),
    .rank_sel_i(rank_sel), .dout_o(dout_w), .cnt_o(cnt_w),
    .dout_vld_o(dv_w), .num_vld_o(nv_w));

  kmin_tracker #(.DW(10), .K(K), .CW(2), .SAT_CNT(1)) u_sat (
    .clk(clk), .rst(rst), .clr_i(clr), .din_i(din), .din_vld_i(din_vld),
    .rank_sel_i(rank_sel), .dout_o(dout_s), .cnt_o(cnt_s),
    .dout_vld_o(dv_s), .num_vld_o(nv_s));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int c, input int cw, input bit sat);
    int m;
    m = 1 << cw;
    if (sat) return (c >= m) ? m - 1 : c;
    return c % m;
  endfunction

  function automatic int mval(input int r);
    return (r < q.size()) ? q[r].val : -1;
  endfunction

  function automatic int mcnt(input int r);
    return (r < q.size()) ? q[r].cnt : -1;
  endfunction

  // Model: the K smallest distinct values as a sorted list with raw counts.
  task automatic model_sample(input int d);
    int pos;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].val == d) begin
        q[i].cnt++;
        return;
      end
    end
    pos = q.size();
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].val > d) pos = i;
    end
    q.insert(pos, '{d, 1});
    if (q.size() > K) void'(q.pop_back());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        chk_en = 1'b1;
      end else if (clr) begin
        q.delete();
        if (din_vld) q.push_back('{int'(din), 1});
      end else if (din_vld) begin
        model_sample(int'(din));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("num_vld_main", int'(nv_m), q.size());
        chk("num_vld_wrap", int'(nv_w), q.size());
        chk("num_vld_sat",  int'(nv_s), q.size());
        for (int r = 0; r < K; r++) begin
          int ev, ec;
          bit vv;
          rank_sel = 2'(r);
          #1;
          vv = (r < q.size());
          ev = vv ? q[r].val : 0;
          ec = vv ? q[r].cnt : 0;
          chk($sformatf("dout_vld_main_r%0d", r), int'(dv_m), int'(vv));
          chk($sformatf("dout_main_r%0d", r), int'(dout_m), ev);
          chk($sformatf("cnt_main_r%0d", r), int'(cnt_m), exp_cnt(ec, 9, 1'b0));
          chk($sformatf("dout_vld_wrap_r%0d", r), int'(dv_w), int'(vv));
          chk($sformatf("dout_wrap_r%0d", r), int'(dout_w), ev);
          chk($sformatf("cnt_wrap_r%0d", r), int'(cnt_w), exp_cnt(ec, 2, 1'b0));
          chk($sformatf("dout_vld_sat_r%0d", r), int'(dv_s), int'(vv));
          chk($sformatf("dout_sat_r%0d", r), int'(dout_s), ev);
          chk($sformatf("cnt_sat_r%0d", r), int'(cnt_s), exp_cnt(ec, 2, 1'b1));
        end
      end
    end
  end

  task automatic send(input int d);
    din_vld = 1'b1;
    din     = 10'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr(input bit with_din, input int d);
    clr     = 1'b1;
    din_vld = with_din;
    din     = 10'(d);
    @(posedge clk);
    #1;
    clr     = 1'b0;
    din_vld = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("lit_reset_size", q.size(), 0);
    idle(1);

    // Basic ordering and hit counting.
    send(5); send(3); send(8); send(3);
    idle(1);
    chk("lit_basic_r0", mval(0), 3);
    chk("lit_basic_c0", mcnt(0), 2);
    chk("lit_basic_r1", mval(1), 5);
    chk("lit_basic_r2", mval(2), 8);
    chk("lit_basic_size", q.size(), 3);

    // Eviction, drop beyond slot K-1, evicted value reappearing.
    do_clr(1'b0, 0);
    send(2); send(4); send(6); send(8); send(5);
    chk("lit_evict_r2", mval(2), 5);
    chk("lit_evict_r3", mval(3), 6);
    send(9);
    send(8);
    idle(1);
    chk("lit_drop_r3", mval(3), 6);
    chk("lit_drop_size", q.size(), 4);
    send(1);
    idle(1);
    chk("lit_reinsert_r0", mval(0), 1);
    chk("lit_reinsert_r3", mval(3), 5);

    // Extremes of the value range.
    do_clr(1'b0, 0);
    send(1023); send(1023); send(0);
    idle(1);
    chk("lit_ext_r0", mval(0), 0);
    chk("lit_ext_r1", mval(1), 1023);
    chk("lit_ext_c1", mcnt(1), 2);

    // Small-counter wrap / saturate (checked per cycle on the CW=2 instances).
    do_clr(1'b0, 0);
    send(10);
    for (int i = 1; i <= 4; i++) begin
      send(20);
      chk($sformatf("lit_ovf_c%0d", i), mcnt(1), i);
    end
    idle(1);

    // Window clear with and without a sample.
    do_clr(1'b0, 0);
    send(2); send(4); send(6);
    do_clr(1'b1, 7);
    chk("lit_clr_size", q.size(), 1);
    chk("lit_clr_r0", mval(0), 7);
    do_clr(1'b0, 0);
    chk("lit_clr_empty", q.size(), 0);
    idle(1);

    // Mixed directed pattern.
    send(7); send(1); send(7); send(9); send(0); send(1); send(3); send(2);
    idle(1);
    chk("lit_mix_r0", mval(0), 0);
    chk("lit_mix_c1", mcnt(1), 2);
    chk("lit_mix_r3", mval(3), 3);

    // Reset mid-stream with din_vld held high.
    send(100); send(50);
    rst = 1'b1;
    din = 10'd77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(60);
    idle(1);
    chk("lit_rst_size", q.size(), 1);
    chk("lit_rst_r0", mval(0), 60);
    chk("lit_rst_c0", mcnt(0), 1);

    // Wide counter wrap at 2**9 hits; slot stays valid with count 0.
    do_clr(1'b0, 0);
    for (int i = 0; i < 512; i++) send(33);
    idle(1);
    chk("lit_wrap512_c0", mcnt(0), 512);
    send(33);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
